// File: rtl/psum_accumulator_if.sv
// Handshake bundle between a PE product source and the partial-sum accumulator.
// The master drives products and commands. The slave is the accumulator.
interface psum_accumulator_if #(
  parameter int unsigned product_width = 20,
  parameter int unsigned acc_width     = 32,
  parameter int unsigned len_width     = 8
);
  // Window control
  logic                        start;
  logic [len_width-1:0]        acc_len;
  logic                        busy;

  // Product stream
  logic                        prod_valid;
  logic signed [product_width-1:0] prod_in;
  logic                        prod_ready;

  // Partial-sum result stream
  logic                        psum_valid;
  logic                        psum_ready;
  logic signed [acc_width-1:0] psum_out;
  logic                        psum_sat;

  modport master (
    output start, acc_len, prod_valid, prod_in, psum_ready,
    input  busy, prod_ready, psum_valid, psum_out, psum_sat
  );

  modport slave (
    input  start, acc_len, prod_valid, prod_in, psum_ready,
    output busy, prod_ready, psum_valid, psum_out, psum_sat
  );
endinterface

// File: rtl/psum_accumulator.sv
// Saturating partial-sum accumulator. A window of acc_len signed products is summed.
// The finished sum is then held on psum_out until the consumer takes it.
module psum_accumulator #(
  parameter int unsigned product_width = 20,
  parameter int unsigned acc_width     = 32,
  parameter int unsigned len_width     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  psum_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  localparam logic signed [acc_width-1:0] AccMax = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] AccMin = {1'b1, {(acc_width-1){1'b0}}};

  state_e state_q, state_d;

  logic signed [acc_width-1:0] acc_q, acc_d;
  logic signed [acc_width-1:0] psum_q, psum_d;
  logic [len_width-1:0]        len_q, len_d;
  logic [len_width-1:0]        count_q, count_d;
  logic                        sat_q, sat_d;

  // One guard bit above the accumulator exposes signed overflow of the add
  logic signed [acc_width:0]   acc_ext, prod_ext, sum_wide;
  logic signed [acc_width-1:0] sum_clamped;
  logic                        clamp;
  logic                        last_prod;

  // Saturating adder: clamp whenever the guard bit disagrees with the result sign
  always_comb begin
    acc_ext  = {acc_q[acc_width-1], acc_q};
    prod_ext = {{(acc_width - product_width + 1){bus.prod_in[product_width-1]}}, bus.prod_in};
    sum_wide = acc_ext + prod_ext;
    clamp    = 1'b0;
    sum_clamped = sum_wide[acc_width-1:0];
    if (!sum_wide[acc_width] && sum_wide[acc_width-1]) begin
      sum_clamped = AccMax;
      clamp       = 1'b1;
    end else if (sum_wide[acc_width] && !sum_wide[acc_width-1]) begin
      sum_clamped = AccMin;
      clamp       = 1'b1;
    end
  end

  // len_q is never zero in StAcc, so len_q - 1 cannot wrap; count tops out at len_q
  assign last_prod = (count_q == len_q - 1'b1);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    psum_d  = psum_q;
    len_d   = len_q;
    count_d = count_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && (bus.acc_len != '0)) begin
          len_d   = bus.acc_len;
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (bus.prod_valid) begin
          acc_d   = sum_clamped;
          count_d = count_q + 1'b1;
          if (clamp) begin
            sat_d = 1'b1;
          end
          if (last_prod) begin
            psum_d  = sum_clamped;
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (bus.psum_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      psum_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      psum_q  <= psum_d;
      len_q   <= len_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  // Status outputs are forced low while rst is high, even before the reset edge lands
  always_comb begin
    bus.prod_ready = !rst && (state_q == StAcc);
    bus.psum_valid = !rst && (state_q == StOut);
    bus.busy       = !rst && (state_q != StIdle);
    bus.psum_out   = psum_q;
    bus.psum_sat   = sat_q;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with an arithmetic reference model.
// The model is checked every cycle.
module tb_psum_accumulator;

  localparam int unsigned PW = 20;
  localparam int unsigned AW = 24;
  localparam int unsigned LW = 8;

  localparam longint AccMax = (longint'(1) << (AW - 1)) - 1;
  localparam longint AccMin = -(longint'(1) << (AW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_accumulator_if #(.product_width(PW), .acc_width(AW), .len_width(LW)) bus ();

  psum_accumulator #(.product_width(PW), .acc_width(AW), .len_width(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. phase 0 = waiting for a window, 1 = collecting products,
  // 2 = holding a result.
  int     phase = 0;
  int     remaining = 0;
  longint m_sum = 0;
  bit     m_sat = 1'b0;
  longint m_out = 0;
  bit     m_out_sat = 1'b0;

  always @(posedge clk) begin : model
    longint s;
    bit     c;
    if (rst) begin
      phase     <= 0;
      m_sum     <= 0;
      m_sat     <= 1'b0;
      m_out     <= 0;
      m_out_sat <= 1'b0;
    end else begin
      case (phase)
        0: if (bus.start && bus.acc_len != 0) begin
          remaining <= int'(bus.acc_len);
          m_sum     <= 0;
          m_sat     <= 1'b0;
          phase     <= 1;
        end
        1: if (bus.prod_valid) begin
          s = m_sum + longint'(bus.prod_in);
          c = 1'b0;
          if (s > AccMax) begin s = AccMax; c = 1'b1; end
          if (s < AccMin) begin s = AccMin; c = 1'b1; end
          m_sum     <= s;
          m_sat     <= m_sat | c;
          remaining <= remaining - 1;
          if (remaining == 1) begin
            m_out     <= s;
            m_out_sat <= m_sat | c;
            phase     <= 2;
          end
        end
        2: if (bus.psum_ready) phase <= 0;
        default: phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", bus.busy, (!rst && phase != 0));
      check("cyc_prod_ready", bus.prod_ready, (!rst && phase == 1));
      check("cyc_psum_valid", bus.psum_valid, (!rst && phase == 2));
      if (!rst && phase == 2) begin
        check("cyc_psum_out", bus.psum_out, m_out);
        check("cyc_psum_sat", bus.psum_sat, m_out_sat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input int len);
    bus.start   = 1'b1;
    bus.acc_len = LW'(len);
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic send(input int p, input int gap);
    bus.prod_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    bus.prod_valid = 1'b1;
    bus.prod_in    = PW'(p);
    tick();
    bus.prod_valid = 1'b0;
  endtask

  task automatic take_psum(input string name);
    bus.psum_ready = 1'b1;
    tick();
    bus.psum_ready = 1'b0;
    check({name, "_valid_drop"}, bus.psum_valid, 0);
    check({name, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.acc_len    = '0;
    bus.prod_valid = 1'b0;
    bus.prod_in    = '0;
    bus.psum_ready = 1'b0;
    rst            = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_psum_out", bus.psum_out, 0);
    check("reset_psum_sat", bus.psum_sat, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_prod_ready", bus.prod_ready, 0);

    // Basic window: 3 - 5 + 100 + 7 = 105
    start_win(4);
    send(3, 0);
    send(-5, 0);
    send(100, 0);
    check("basic_not_early", bus.psum_valid, 0);
    send(7, 0);
    check("basic_valid_next", bus.psum_valid, 1);
    check("basic_sum", bus.psum_out, 105);
    check("basic_model_pin", m_out, 105);
    check("basic_sat", bus.psum_sat, 0);
    take_psum("basic");

    // Stalls and backpressure: 10 + 20 + 30 = 60 held under psum_ready = 0
    start_win(3);
    send(10, 2);
    send(20, 2);
    send(30, 2);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", bus.psum_valid, 1);
      check("bp_hold_sum", bus.psum_out, 60);
      tick();
    end
    check("bp_model_pin", m_out, 60);
    take_psum("bp");

    // Saturation: 255 * (2^19 - 1) clamps to 2^23 - 1
    start_win(255);
    for (int i = 0; i < 255; i++) send(524287, 0);
    check("sat_valid", bus.psum_valid, 1);
    check("sat_sum", bus.psum_out, 8388607);
    check("sat_flag", bus.psum_sat, 1);
    check("sat_model_pin", m_out, 8388607);
    take_psum("sat");
    start_win(1);
    send(-1, 0);
    check("sat_next_sum", bus.psum_out, -1);
    check("sat_next_flag", bus.psum_sat, 0);
    take_psum("sat_next");

    // Zero length start is ignored; products in IDLE do not leak into the next window
    bus.start      = 1'b1;
    bus.acc_len    = '0;
    bus.prod_valid = 1'b1;
    bus.prod_in    = PW'(999);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("zero_busy", bus.busy, 0);
      check("zero_prod_ready", bus.prod_ready, 0);
      check("zero_psum_valid", bus.psum_valid, 0);
      tick();
    end
    bus.prod_valid = 1'b0;
    start_win(1);
    send(5, 0);
    check("idle_prod_ignored", bus.psum_out, 5);
    take_psum("idle_prod");

    // Start in ACC is ignored: window keeps length 4, 1 + 2 + 3 + 4 = 10
    start_win(4);
    send(1, 0);
    send(2, 0);
    bus.start   = 1'b1;
    bus.acc_len = LW'(1);
    tick();
    bus.start   = 1'b0;
    send(3, 0);
    check("ign_start_not_early", bus.psum_valid, 0);
    send(4, 0);
    check("ign_start_valid", bus.psum_valid, 1);
    check("ign_start_sum", bus.psum_out, 10);
    take_psum("ign_start");

    // Reset wins over start in the same cycle
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.acc_len = LW'(3);
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_prio_busy", bus.busy, 0);

    // Mid-window reset discards the partial sum
    start_win(5);
    send(1, 0);
    send(2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_prod_ready", bus.prod_ready, 0);
    check("midrst_psum_valid", bus.psum_valid, 0);
    check("midrst_psum_out", bus.psum_out, 0);
    check("midrst_psum_sat", bus.psum_sat, 0);
    start_win(2);
    send(-8, 0);
    send(-8, 0);
    check("midrst_new_sum", bus.psum_out, -16);
    check("midrst_model_pin", m_out, -16);
    take_psum("midrst_new");

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 The block SHALL have parameter product_width, default 20, meaning the signed width of one incoming PE product.
REQ-002 The block SHALL have parameter acc_width, default 32, meaning the signed width of the accumulator and partial-sum output; acc_width SHALL be at least product_width.
REQ-003 The block SHALL have parameter len_width, default 8, meaning the width of the accumulation-length field.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port start, input, 1, one-cycle request to begin a new accumulation window.
REQ-008 Port acc_len, input, len_width, number of products in the window (unsigned), sampled with start.
REQ-009 Port prod_valid, input, 1, product on prod_in is valid.
REQ-010 Port prod_in, input, product_width, signed PE product.
REQ-011 Port prod_ready, output, 1, block accepts a product this cycle.
REQ-012 Port psum_valid, output, 1, psum_out holds a finished partial sum.
REQ-013 Port psum_ready, input, 1, downstream accepts psum_out this cycle.
REQ-014 Port psum_out, output, acc_width, signed finished partial sum.
REQ-015 Port psum_sat, output, 1, psum_out was clamped during this window.
REQ-016 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 The block SHALL implement the states IDLE, ACC and OUT.
REQ-018 In IDLE, a start with acc_len >= 1 SHALL latch acc_len, clear the accumulator, the count and the saturation flag, and move to ACC on the next cycle.
REQ-019 In IDLE, a start with acc_len == 0 SHALL be ignored, and the block SHALL stay in IDLE.
REQ-020 The block SHALL sample start only in IDLE and SHALL ignore it in ACC and OUT.
REQ-021 prod_ready SHALL be 1 exactly when the state is ACC.
REQ-022 A product SHALL be accepted only in a cycle where prod_valid and prod_ready are both 1.
REQ-023 The block SHALL hold its state in a cycle where prod_valid is 0 (stall).
REQ-024 On each accepted product, the accumulator SHALL add prod_in sign-extended to acc_width, and the count SHALL increment by 1.
REQ-025 Addition SHALL saturate to [-2^(acc_width-1), 2^(acc_width-1)-1]; on clamping, psum_sat SHALL become 1 and stay 1 until the next window starts.
REQ-026 When the accepted product is number acc_len, the block SHALL register the final sum into psum_out and move to OUT, so that psum_valid rises on the cycle after the last accept.
REQ-027 In OUT, psum_valid SHALL be 1, and psum_out and psum_sat SHALL stay stable until psum_ready is 1.
REQ-028 A psum_valid and psum_ready handshake SHALL return the block to IDLE on the next cycle, and psum_valid SHALL drop in that same next cycle.
REQ-029 An acc_len of 2^len_width-1 SHALL be supported, and the count SHALL not wrap before the last product.
REQ-030 Products presented outside ACC SHALL be ignored and SHALL not change the accumulator.

Reset
REQ-031 While rst is 1 at a clock edge, the next state SHALL be IDLE, and psum_out, the accumulator, the count and psum_sat SHALL be 0.
REQ-032 While rst is 1, prod_ready, psum_valid and busy SHALL be 0.
REQ-033 A reset during ACC or OUT SHALL discard the partial window with no psum handshake.
REQ-034 rst SHALL take priority over start and over both handshakes in the same cycle.

Verification
REQ-035 Basic window: start with acc_len=4; products 3, -5, 100, 7, each with prod_valid=1 -> psum_valid rises the cycle after the 4th accept; psum_out=105; psum_sat=0.
REQ-036 Stalls and backpressure: acc_len=3; products 10, 20, 30 with prod_valid gaps of 2 cycles; psum_ready held 0 for 5 cycles -> psum_out stays 60 and valid stays high; after the handshake, busy=0.
REQ-037 Saturation with acc_width=24: acc_len=255; every product = +2^19-1 -> psum_out=2^23-1; psum_sat=1; the next window with acc_len=1 and product -1 gives psum_out=-1 and psum_sat=0.
REQ-038 Zero length: start with acc_len=0 -> busy stays 0; prod_ready stays 0; no psum_valid.
REQ-039 Ignored start: a start pulse in ACC after 2 of 4 products -> the window completes with the original length 4 and the correct sum.
REQ-040 Mid-operation reset: rst=1 for 1 cycle after 2 of 5 products -> all outputs are 0 the next cycle; a new window with acc_len=2 and products -8, -8 gives psum_out=-16.
